// File: rtl/image_top_processor.sv
// Image-sampling processor: UART-loaded pixel RAM, 2:1 pair-average downsample, UART readback.
// Define ROUND_AVG_EN to round pair averages half up instead of truncating.
`timescale 1ns/1ps
module image_top_processor #(
  parameter int CLKS_PER_BIT = 16,
  parameter int MEM_DEPTH    = 256,
  parameter int ADDR_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic enablle,
  output logic enable_check,
  input  logic resume_sw,
  output logic pause_LED,
  output logic fetch_LED,
  input  logic send,
  input  logic receive,
  input  logic rx,
  output logic tx,
  output logic tx_LED,
  output logic rx_LED
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(MEM_DEPTH / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RXBLK, S_FETCH_A, S_FETCH_B, S_EXEC, S_WRITE, S_PAUSE, S_TXBLK
  } state_e;

  state_e state_q, state_d;
  logic enable_check_q, enable_check_d;
  logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic rx_prev_q, rx_prev_d, res_prev_q, res_prev_d;
  logic tx_q, tx_d;
  logic rx_busy_q, rx_busy_d;
  logic [3:0] rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d, a_q, a_d, avg_q, avg_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d, pptr_q, pptr_d, tptr_q, tptr_d;
  logic loaded_q, loaded_d, processed_q, processed_d;

  logic [7:0] mem [MEM_DEPTH];
  logic [7:0] rd_dat_q;
  logic       mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0] mem_wdat;
  logic [8:0] sum;

  logic rx_s, res_s, send_s, recv_s;
  assign {rx_s, res_s, send_s, recv_s} = sync2_q;

  always_comb begin
    state_d        = state_q;
    enable_check_d = enablle;
    sync1_d        = {rx, resume_sw, send, receive};
    sync2_d        = sync1_q;
    rx_prev_d      = rx_s;
    res_prev_d     = res_s;
    tx_d           = 1'b1;
    rx_busy_d      = rx_busy_q;
    rx_bit_d       = rx_bit_q;
    rx_cnt_d       = rx_cnt_q;
    rx_shift_d     = rx_shift_q;
    tx_bit_d       = tx_bit_q;
    tx_cnt_d       = tx_cnt_q;
    a_d            = a_q;
    avg_d          = avg_q;
    wptr_d         = wptr_q;
    pptr_d         = pptr_q;
    tptr_d         = tptr_q;
    loaded_d       = loaded_q;
    processed_d    = processed_q;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdat       = avg_q;
    sum            = '0;

    case (state_q)
      S_IDLE: begin
        tptr_d = '0;
        pptr_d = '0;
        if (enablle) begin
          if (recv_s) begin
            state_d   = S_RXBLK;
            rx_busy_d = 1'b0;
            wptr_d    = '0;
          end else if (send_s) begin
            state_d  = S_TXBLK;
            tx_bit_d = '0;
            tx_cnt_d = '0;
          end else if (loaded_q && !processed_q) begin
            state_d = S_FETCH_A;
          end
        end
        // RAM address follows the next tptr so byte 0 is already read on TX entry
        mem_addr = tptr_d;
      end

      S_RXBLK: begin
        mem_addr = wptr_q;
        mem_wdat = rx_shift_q;
        if (!rx_busy_q) begin
          if (rx_prev_q && !rx_s) begin
            rx_busy_d = 1'b1;
            rx_cnt_d  = '0;
            rx_bit_d  = '0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
          if (rx_bit_q == 4'd0) begin
            if (rx_cnt_q == CNT_HALF) begin
              rx_cnt_d = '0;
              if (!rx_s) rx_bit_d = 4'd1;
              else       rx_busy_d = 1'b0;
            end
          end else if (rx_cnt_q == CNT_LAST) begin
            rx_cnt_d = '0;
            if (rx_bit_q == 4'd9) begin
              rx_busy_d = 1'b0;
              if (rx_s) begin
                mem_we = 1'b1;
                wptr_d = wptr_q + 1'b1;
                if (wptr_q == LAST_BYTE) begin
                  state_d     = S_IDLE;
                  loaded_d    = 1'b1;
                  processed_d = 1'b0;
                  wptr_d      = '0;
                end
              end
            end else begin
              rx_shift_d = {rx_s, rx_shift_q[7:1]};
              rx_bit_d   = rx_bit_q + 1'b1;
            end
          end
        end
      end

      S_FETCH_A: begin
        mem_addr = {pptr_q[ADDR_W-2:0], 1'b0};
        state_d  = S_FETCH_B;
      end

      S_FETCH_B: begin
        mem_addr = {pptr_q[ADDR_W-2:0], 1'b1};
        a_d      = rd_dat_q;
        state_d  = S_EXEC;
      end

      S_EXEC: begin
`ifdef ROUND_AVG_EN
        sum = {1'b0, a_q} + {1'b0, rd_dat_q} + 9'd1;
`else
        sum = {1'b0, a_q} + {1'b0, rd_dat_q};
`endif
        avg_d   = 8'(sum >> 1);
        state_d = S_WRITE;
      end

      S_WRITE: begin
        // In-place write is safe: pair index i never exceeds source address 2i
        mem_we   = 1'b1;
        mem_addr = pptr_q;
        mem_wdat = avg_q;
        if (pptr_q == LAST_PAIR) begin
          state_d     = S_PAUSE;
          processed_d = 1'b1;
          loaded_d    = 1'b0;
        end else begin
          pptr_d  = pptr_q + 1'b1;
          state_d = S_FETCH_A;
        end
      end

      S_PAUSE: begin
        if (res_s && !res_prev_q) state_d = S_IDLE;
      end

      S_TXBLK: begin
        case (tx_bit_q)
          4'd0:    tx_d = 1'b0;
          4'd9:    tx_d = 1'b1;
          default: tx_d = rd_dat_q[3'(tx_bit_q - 4'd1)];
        endcase
        tx_cnt_d = tx_cnt_q + 1'b1;
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd9) begin
            tx_bit_d = '0;
            if (tptr_q == LAST_PAIR) begin
              state_d = S_IDLE;
              tptr_d  = '0;
            end else begin
              tptr_d = tptr_q + 1'b1;
            end
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end
        mem_addr = tptr_d;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      enable_check_q <= 1'b0;
      sync1_q        <= 4'b1000;
      sync2_q        <= 4'b1000;
      rx_prev_q      <= 1'b1;
      res_prev_q     <= 1'b0;
      tx_q           <= 1'b1;
      rx_busy_q      <= 1'b0;
      rx_bit_q       <= '0;
      rx_cnt_q       <= '0;
      rx_shift_q     <= '0;
      tx_bit_q       <= '0;
      tx_cnt_q       <= '0;
      a_q            <= '0;
      avg_q          <= '0;
      wptr_q         <= '0;
      pptr_q         <= '0;
      tptr_q         <= '0;
      loaded_q       <= 1'b0;
      processed_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      enable_check_q <= enable_check_d;
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      rx_prev_q      <= rx_prev_d;
      res_prev_q     <= res_prev_d;
      tx_q           <= tx_d;
      rx_busy_q      <= rx_busy_d;
      rx_bit_q       <= rx_bit_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_shift_q     <= rx_shift_d;
      tx_bit_q       <= tx_bit_d;
      tx_cnt_q       <= tx_cnt_d;
      a_q            <= a_d;
      avg_q          <= avg_d;
      wptr_q         <= wptr_d;
      pptr_q         <= pptr_d;
      tptr_q         <= tptr_d;
      loaded_q       <= loaded_d;
      processed_q    <= processed_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdat;
    rd_dat_q <= mem[mem_addr];
  end

  assign enable_check = enable_check_q;
  assign tx           = tx_q;
  assign pause_LED    = (state_q == S_PAUSE);
  assign fetch_LED    = (state_q == S_FETCH_A) || (state_q == S_FETCH_B);
  assign tx_LED       = (state_q == S_TXBLK);
  assign rx_LED       = (state_q == S_RXBLK);

endmodule

// File: tb/tb_image_top_processor.sv
// Directed bench for image_top_processor with an 8-byte RAM and 16 clocks per UART bit.
// Latency: checks sampled on negedge after bounded waits on LED/tx events.
// Backpressure: none; stimulus drives the DUT pins directly.
`timescale 1ns/1ps
module tb_image_top_processor;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enablle = 1'b1;
    logic resume_sw = 1'b0;
    logic send = 1'b0;
    logic receive = 1'b0;
    logic rx = 1'b1;
    logic enable_check, pause_LED, fetch_LED, tx, tx_LED, rx_LED;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fetch_rises = 0;
    logic fetch_prev = 1'b0;

    logic [7:0] blk1 [8] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd255, 8'd255};
    logic [7:0] avg1 [4] = '{8'd15, 8'd35, 8'd55, 8'd255};
    logic [7:0] blk2 [8] = '{8'hA1, 8'hC3, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
`ifdef ROUND_AVG_EN
    logic [7:0] avg2 [4] = '{8'hB2, 8'h02, 8'h04, 8'h06};
`else
    logic [7:0] avg2 [4] = '{8'hB2, 8'h01, 8'h03, 8'h05};
`endif

    image_top_processor #(.CLKS_PER_BIT(CPB), .MEM_DEPTH(8), .ADDR_W(3)) dut (
        .clk(clk), .reset(reset), .enablle(enablle), .enable_check(enable_check),
        .resume_sw(resume_sw), .pause_LED(pause_LED), .fetch_LED(fetch_LED),
        .send(send), .receive(receive), .rx(rx), .tx(tx), .tx_LED(tx_LED), .rx_LED(rx_LED)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (fetch_LED && !fetch_prev) fetch_rises = fetch_rises + 1;
        fetch_prev = fetch_LED;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic uart_put(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_bit;
        tick(CPB);
        rx = 1'b1;
        tick(4);
    endtask

    task automatic uart_get(output logic [7:0] b, output int st, output logic stp);
        int k;
        b = '0;
        st = -1;
        stp = 1'b0;
        k = 0;
        while (tx !== 1'b0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (tx === 1'b0) begin
            st = cyc;
            tick(CPB / 2);
            for (int i = 0; i < 8; i++) begin
                tick(CPB);
                b[i] = tx;
            end
            tick(CPB);
            stp = tx;
        end
    endtask

    initial begin
        logic [7:0] got;
        int st, prev_st, base;
        logic stp;

        tick(10);
        chk("rst_tx", tx, 1'b1);
        chk("rst_leds", {pause_LED, fetch_LED, tx_LED, rx_LED}, 4'b0000);
        chk("rst_en_chk", enable_check, 1'b0);
        reset = 1'b0;
        tick(1);
        chk("en_chk_1cyc", enable_check, 1'b1);
        tick(10);
        chk("idle_leds", {pause_LED, fetch_LED, tx_LED, rx_LED}, 4'b0000);

        receive = 1'b1;
        for (int k = 0; k < 20 && rx_LED !== 1'b1; k++) tick(1);
        chk("rx_led_on", rx_LED, 1'b1);
        receive = 1'b0;
        base = fetch_rises;
        for (int k = 0; k < 8; k++) begin
            uart_put(blk1[k], 1'b1);
            chk("rx1_mem", dut.mem[k], blk1[k]);
            if (k < 7) chk("rx1_led_hold", rx_LED, 1'b1);
        end
        for (int k = 0; k < 200 && pause_LED !== 1'b1; k++) tick(1);
        chk("p1_pause", pause_LED, 1'b1);
        chk("p1_fetch_pulses", fetch_rises - base, 4);
        chk("p1_rx_led_off", rx_LED, 1'b0);
        for (int k = 0; k < 4; k++) chk("p1_avg", dut.mem[k], avg1[k]);
        for (int k = 4; k < 8; k++) chk("p1_upper", dut.mem[k], blk1[k]);

        resume_sw = 1'b1;
        for (int k = 0; k < 20 && pause_LED !== 1'b0; k++) tick(1);
        chk("p1_resume", pause_LED, 1'b0);
        tick(5);
        chk("p1_idle", {pause_LED, fetch_LED, tx_LED, rx_LED}, 4'b0000);

        send = 1'b1;
        for (int k = 0; k < 20 && tx_LED !== 1'b1; k++) tick(1);
        chk("tx_led_on", tx_LED, 1'b1);
        send = 1'b0;
        prev_st = 0;
        for (int f = 0; f < 4; f++) begin
            uart_get(got, st, stp);
            chk("tx_byte", got, avg1[f]);
            chk("tx_stop", stp, 1'b1);
            if (f > 0) chk("tx_frame_len", st - prev_st, 10 * CPB);
            prev_st = st;
        end
        for (int k = 0; k < 100 && tx_LED !== 1'b0; k++) tick(1);
        chk("tx_led_off", tx_LED, 1'b0);
        chk("tx_idle_high", tx, 1'b1);

        receive = 1'b1;
        send = 1'b1;
        for (int k = 0; k < 20 && rx_LED !== 1'b1; k++) tick(1);
        chk("both_rx", rx_LED, 1'b1);
        chk("both_no_tx", tx_LED, 1'b0);
        receive = 1'b0;
        send = 1'b0;
        tick(10);
        chk("both_tx_high", tx, 1'b1);
        uart_put(blk2[0], 1'b1);
        chk("rx2_mem0", dut.mem[0], blk2[0]);
        uart_put(8'h5B, 1'b0);
        chk("bad_wptr", dut.wptr_q, 3'd1);
        uart_put(blk2[1], 1'b1);
        chk("after_bad_mem1", dut.mem[1], blk2[1]);
        chk("after_bad_wptr", dut.wptr_q, 3'd2);
        base = fetch_rises;
        for (int k = 2; k < 8; k++) uart_put(blk2[k], 1'b1);
        for (int k = 0; k < 200 && pause_LED !== 1'b1; k++) tick(1);
        chk("p2_pause", pause_LED, 1'b1);
        chk("p2_fetch_pulses", fetch_rises - base, 4);
        for (int k = 0; k < 4; k++) chk("p2_avg", dut.mem[k], avg2[k]);

        tick(20);
        chk("p2_hold_high", pause_LED, 1'b1);
        resume_sw = 1'b0;
        tick(5);
        chk("p2_hold_low", pause_LED, 1'b1);
        resume_sw = 1'b1;
        for (int k = 0; k < 20 && pause_LED !== 1'b0; k++) tick(1);
        chk("p2_resume", pause_LED, 1'b0);

        enablle = 1'b0;
        receive = 1'b1;
        send = 1'b1;
        tick(30);
        chk("dis_leds", {pause_LED, fetch_LED, tx_LED, rx_LED}, 4'b0000);
        chk("dis_tx", tx, 1'b1);
        chk("dis_en_chk", enable_check, 1'b0);
        receive = 1'b0;
        send = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
